// File: rtl/reg_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit register (with complement output)
// between NREQ requesters, each posting LOAD/SET/CLEAR/TOGGLE operations.
module reg_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [2*NREQ-1:0]       i_op,
  input  logic [WIDTH*NREQ-1:0]   i_wdata,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_done,
  output logic                    o_busy,
  output logic [WIDTH-1:0]        o_q,
  output logic [WIDTH-1:0]        o_n_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_done, w_done_nxt;
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic [1:0]        r_op_lat, w_op_lat_nxt;
  logic [WIDTH-1:0]  r_data_lat, w_data_lat_nxt;

  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [1:0]        w_win_op;
  logic [WIDTH-1:0]  w_win_data;
  logic [NREQ-1:0]   w_win_oh;

  // Scan upward from r_ptr with wrap; the first requesting index wins.
  always_comb begin : arb_scan
    int unsigned s;
    logic [PW-1:0] cand;
    w_found    = 1'b0;
    w_win      = '0;
    w_win_op   = '0;
    w_win_data = '0;
    s          = 0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      s = 32'(r_ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      cand = PW'(s);
      if (!w_found && i_req[cand]) begin
        w_found    = 1'b1;
        w_win      = cand;
        w_win_op   = i_op[2*s +: 2];
        w_win_data = i_wdata[WIDTH*s +: WIDTH];
      end
    end
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gnt_nxt      = r_gnt;
    w_done_nxt     = r_done;
    w_q_nxt        = r_q;
    w_op_lat_nxt   = r_op_lat;
    w_data_lat_nxt = r_data_lat;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_op_lat_nxt   = w_win_op;
          w_data_lat_nxt = w_win_data;
          w_gnt_nxt      = w_win_oh;
          w_ptr_nxt      = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
          w_state_nxt    = EXEC;
        end
      end
      EXEC: begin
        case (r_op_lat)
          2'b00:   w_q_nxt = r_data_lat;
          2'b01:   w_q_nxt = '1;
          2'b10:   w_q_nxt = '0;
          default: w_q_nxt = ~r_q;
        endcase
        w_done_nxt  = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_gnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_done     <= 1'b0;
      r_q        <= '0;
      r_op_lat   <= '0;
      r_data_lat <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_q        <= w_q_nxt;
      r_op_lat   <= w_op_lat_nxt;
      r_data_lat <= w_data_lat_nxt;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_done = r_done;
  assign o_busy = (r_state != IDLE);
  assign o_q    = r_q;
  assign o_n_q  = ~r_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed self-checking bench for reg_share_arb (WIDTH=8, NREQ=4).
module tb_reg_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        done;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  n_q;

  int unsigned total;
  int unsigned passed;
  int unsigned fails;

  reg_share_arb #(.WIDTH(8), .NREQ(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_op    (op),
    .i_wdata (wdata),
    .o_gnt   (gnt),
    .o_done  (done),
    .o_busy  (busy),
    .o_q     (q),
    .o_n_q   (n_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [1:0] o, input logic [7:0] d);
    op[2*i +: 2]    = o;
    wdata[8*i +: 8] = d;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_q"},    q,    32'h00);
    chk({tag, "_nq"},   n_q,  32'hFF);
    chk({tag, "_gnt"},  gnt,  32'h0);
    chk({tag, "_done"}, done, 32'h0);
    chk({tag, "_busy"}, busy, 32'h0);
  endtask

  // One full grant: E0 grant/busy, E1 q update + done pulse, E2 release.
  task automatic op_cycle(input string tag, input logic [3:0] exp_gnt,
                          input logic [7:0] q_before, input logic [7:0] exp_q,
                          input bit drop_req);
    tick();
    chk({tag, "_E0_gnt"},  gnt,  {28'h0, exp_gnt});
    chk({tag, "_E0_busy"}, busy, 32'h1);
    chk({tag, "_E0_done"}, done, 32'h0);
    chk({tag, "_E0_q"},    q,    {24'h0, q_before});
    tick();
    chk({tag, "_E1_q"},    q,    {24'h0, exp_q});
    chk({tag, "_E1_nq"},   n_q,  {24'h0, ~exp_q});
    chk({tag, "_E1_done"}, done, 32'h1);
    chk({tag, "_E1_gnt"},  gnt,  {28'h0, exp_gnt});
    if (drop_req) req = 4'b0000;
    tick();
    chk({tag, "_E2_gnt"},  gnt,  32'h0);
    chk({tag, "_E2_done"}, done, 32'h0);
    chk({tag, "_E2_busy"}, busy, 32'h0);
    chk({tag, "_E2_q"},    q,    {24'h0, exp_q});
  endtask

  task automatic run_op(input string tag, input int r, input logic [1:0] o,
                        input logic [7:0] d, input logic [7:0] q_before,
                        input logic [7:0] exp_q);
    set_slot(r, o, d);
    req = 4'b0001 << r;
    op_cycle(tag, 4'b0001 << r, q_before, exp_q, 1'b1);
  endtask

  initial begin
    logic [3:0] fair_seq [5];
    total  = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b1;
    req    = '0;
    op     = '0;
    wdata  = '0;

    // Asynchronous reset takes effect mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1 chk_idle_reset("rst_async");
    tick();
    tick();
    chk_idle_reset("rst_hold");
    rst_n = 1'b1;

    run_op("load0", 0, 2'b00, 8'hA5, 8'h00, 8'hA5);

    run_op("set2",  2, 2'b01, 8'h00, 8'hA5, 8'hFF);
    run_op("clr2",  2, 2'b10, 8'h00, 8'hFF, 8'h00);
    run_op("tgl2a", 2, 2'b11, 8'h00, 8'h00, 8'hFF);
    run_op("tgl2b", 2, 2'b11, 8'h00, 8'hFF, 8'h00);

    // Fresh reset so the pointer restarts at requester 0.
    #2 rst_n = 1'b0;
    #1 chk_idle_reset("rst_mid");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) set_slot(i, 2'b00, 8'h10 + 8'(i));
    fair_seq[0] = 4'b0001;
    fair_seq[1] = 4'b0010;
    fair_seq[2] = 4'b0100;
    fair_seq[3] = 4'b1000;
    fair_seq[4] = 4'b0001;
    req = 4'b1111;
    op_cycle("fair0", fair_seq[0], 8'h00, 8'h10, 1'b0);
    op_cycle("fair1", fair_seq[1], 8'h10, 8'h11, 1'b0);
    op_cycle("fair2", fair_seq[2], 8'h11, 8'h12, 1'b0);
    op_cycle("fair3", fair_seq[3], 8'h12, 8'h13, 1'b0);
    op_cycle("fair4", fair_seq[4], 8'h13, 8'h10, 1'b0);

    req = 4'b1001;
    op_cycle("pair3", 4'b1000, 8'h10, 8'h13, 1'b0);
    op_cycle("pair0", 4'b0001, 8'h13, 8'h10, 1'b1);

    // Inputs of the granted requester change during EXEC; captured values win.
    set_slot(1, 2'b00, 8'h77);
    req = 4'b0010;
    tick();
    chk("mid_E0_gnt", gnt, 32'h2);
    set_slot(1, 2'b01, 8'h00);
    req = 4'b0100;
    tick();
    chk("mid_E1_q",    q,    32'h77);
    chk("mid_E1_nq",   n_q,  32'h88);
    chk("mid_E1_done", done, 32'h1);
    req = 4'b0000;
    tick();
    chk("mid_E2_gnt",  gnt,  32'h0);

    run_op("pre_rst", 2, 2'b00, 8'h11, 8'h77, 8'h11);

    // Reset while a LOAD of 0x3C is in EXEC: operation must be discarded.
    set_slot(0, 2'b00, 8'h3C);
    req = 4'b0001;
    tick();
    chk("rexec_E0_gnt", gnt, 32'h1);
    chk("rexec_E0_q",   q,   32'h11);
    #2 rst_n = 1'b0;
    req = 4'b0000;
    #1 chk_idle_reset("rexec_async");
    tick();
    chk_idle_reset("rexec_hold");
    rst_n = 1'b1;

    req = 4'b1001;
    op_cycle("post_rst", 4'b0001, 8'h00, 8'h3C, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin controller that shares one WIDTH-bit register, with complementary outputs, between NREQ requesters. Each requester posts an operation: load, set-all, clear-all or toggle. The block grants one requester at a time and performs the operation on the owned register. It sits between several client blocks and a single shared state register in the flip-flop datapath family.

## Interface
- WIDTH, 8, register width in bits (≥1)
- NREQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- req  in  NREQ  level request, bit i = requester i
- op  in  2*NREQ  op of requester i at [2i+1:2i]: 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE
- wdata  in  WIDTH*NREQ  load data of requester i at [WIDTH*i +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- done  out  1  one-cycle completion pulse, registered
- busy  out  1  high whenever state ≠ IDLE
- q  out  WIDTH  shared register value
- n_q  out  WIDTH  always ~q

## Operation
- States: IDLE, EXEC, DONE. Any unused encoding goes to IDLE on the next edge.
- IDLE, req≠0:
  - Select the winner: the first set req bit scanning upward from ptr, wrapping at NREQ-1→0.
  - Capture the winner's op and wdata into op_lat/data_lat.
  - gnt ← onehot(winner); ptr ← (winner+1) mod NREQ; state ← EXEC.
- IDLE, req=0: hold all state.
- EXEC: apply op_lat to q; done ← 1; state ← DONE.
  - LOAD: q ← data_lat
  - SET: q ← all ones
  - CLEAR: q ← all zeros
  - TOGGLE: q ← ~q
  - n_q ← complement of the new q in the same edge.
- DONE: gnt ← 0; done ← 0; state ← IDLE.
- Arbitration happens only in IDLE. req/op/wdata changes during EXEC or DONE do not affect the operation in flight.
- req is a level signal. The granted requester must drop req once it sees done. If it is still high in the following IDLE cycle, that is a new request, arbitrated fairly from the rotated ptr.
- q and n_q change only at the EXEC→DONE edge or on reset.
- Reset (asynchronous, any time, including mid-EXEC):
  - state=IDLE, ptr=0, gnt=0, done=0, busy=0, q=0, n_q=all ones, op_lat/data_lat=0.
  - An operation interrupted by reset is discarded; q does not take its value.

## Timing
- Edge E0 (IDLE, req sampled non-zero): gnt and busy high from E0 until E2.
- Edge E1: q/n_q update; done high for exactly the cycle E1..E2.
- Edge E2: gnt/done low; busy low. Earliest next grant is at E3.
- Request-to-q latency: 2 edges. Throughput: one operation per 3 cycles under continuous requests.
- Simultaneous requests: with all NREQ requesting from reset, grants go 0,1,…,NREQ-1,0,… with no starvation. A requester waits at most NREQ-1 operations.
- Reset deassertion is synchronised externally. The first arbitration occurs on the first rising edge with Reset high.

## Test plan
- Reset: assert Reset=0 mid-cycle → immediately q=0x00, n_q=0xFF, gnt=0, done=0, busy=0; all hold across clocks while Reset=0.
- Single LOAD: req=0001, op0=00, wdata0=0xA5 → gnt=0001 at E0, q=0xA5 and n_q=0x5A at E1, done pulse one cycle, gnt=0 at E2.
- Op set on requester 2 (q starts at 0xA5): SET → q=0xFF; then CLEAR → 0x00; then TOGGLE twice → 0xFF, then 0x00. n_q is always the complement.
- Fairness:
  - req=1111 held high → gnt sequence 0001, 0010, 0100, 1000, 0001, each separated by 3 cycles.
  - Then req=1001 with ptr=1 → grants 1000, then 0001.
- Mid-operation changes: change op/wdata/req of the granted requester during EXEC → q takes the value captured at E0.
- Reset during EXEC (LOAD 0x3C pending, q=0x11) → q=0x00, no done pulse. Next grant starts from requester 0.
